// File: rtl/hdd_rate_probe.sv
// hdd_rate_probe
// ---------------------------------------------------------------------------
// Measures flux-transition intervals on the selected HDD read-data line over
// a fixed window. It builds a 16-bin histogram (16 clk per bin) and scans it
// for the shortest and longest populated bins. From those it classifies the
// drive as MFM 5M, RLL 7.5M or ESDI 10M.
//
// Optional build macro: HDD_RATE_HIST_READBACK_EN
//   adds hist_sel[3:0] / hist_count[15:0] for registered histogram readback.
//
// Ports
//   clk               300 MHz HDD clock
//   reset_n           synchronous active-low reset
//   probe_start       start pulse, accepted in IDLE only
//   use_differential  source select, latched on the accepted start
//   read_data_se      single-ended read data
//   read_data_p/_n    differential read data (used as p^n)
//   index_pulse       index reference; opens the sample window
//   probe_busy        high from the cycle after start until DONE
//   probe_done        one-cycle pulse when results are final
//   rate_valid        rate_code != 0
//   rate_code         0 unknown, 1 MFM, 2 RLL, 3 ESDI
//   min_bin/max_bin   lowest/highest populated bin (0 if none)
//   total_intervals   binned intervals (saturating)
//   overflow_count    intervals >= 256 clk (saturating)
//   glitch_count      intervals < GLITCH_MIN (saturating)
// ---------------------------------------------------------------------------
module hdd_rate_probe #(
   parameter logic [23:0] WINDOW       = 24'd1_500_000,
   parameter logic [9:0]  GLITCH_MIN   = 10'd10,
   parameter logic [15:0] MIN_BIN_HITS = 16'd64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        probe_start,
   input  logic        use_differential,
   input  logic        read_data_se,
   input  logic        read_data_p,
   input  logic        read_data_n,
   input  logic        index_pulse,
`ifdef HDD_RATE_HIST_READBACK_EN
   input  logic [3:0]  hist_sel,
   output logic [15:0] hist_count,
`endif
   output logic        probe_busy,
   output logic        probe_done,
   output logic        rate_valid,
   output logic [1:0]  rate_code,
   output logic [3:0]  min_bin,
   output logic [3:0]  max_bin,
   output logic [15:0] total_intervals,
   output logic [15:0] overflow_count,
   output logic [7:0]  glitch_count
);

   typedef enum logic [2:0] {IDLE, WAIT_INDEX, SAMPLE, SCAN, CLASSIFY, DONE} state_t;

   state_t             state;
   logic               src_diff;
   logic               d_prev;
   logic               first_edge;
   logic               found;
   logic [24:0]        sample_counter;   // one bit wider so it can exceed WINDOW
   logic [9:0]         interval;
   logic [3:0]         scan_idx;
   logic [15:0][15:0]  hist;

   logic               d;
   logic               flux_edge;
   logic [9:0]         ival_next;
   logic [1:0]         code;

   assign d         = src_diff ? (read_data_p ^ read_data_n) : read_data_se;
   assign flux_edge = d ^ d_prev;
   // Interval value as seen on this cycle; equals the clk distance between
   // the previous edge and this one.
   assign ival_next = (interval == 10'h3FF) ? interval : interval + 10'd1;

   always_comb begin
      code = 2'd0;
      if (found) begin
         if (min_bin == 4'd1 || min_bin == 4'd2)
            code = 2'd3;
         else if (min_bin == 4'd3 || min_bin == 4'd4)
            code = (max_bin >= 4'd9) ? 2'd2 : 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= IDLE;
         src_diff        <= 1'b0;
         d_prev          <= 1'b0;
         first_edge      <= 1'b0;
         found           <= 1'b0;
         sample_counter  <= '0;
         interval        <= '0;
         scan_idx        <= '0;
         hist            <= '0;
         probe_busy      <= 1'b0;
         probe_done      <= 1'b0;
         rate_valid      <= 1'b0;
         rate_code       <= '0;
         min_bin         <= '0;
         max_bin         <= '0;
         total_intervals <= '0;
         overflow_count  <= '0;
         glitch_count    <= '0;
      end else begin
         d_prev <= d;
         case (state)
            IDLE: begin
               if (probe_start) begin
                  src_diff        <= use_differential;
                  hist            <= '0;
                  total_intervals <= '0;
                  overflow_count  <= '0;
                  glitch_count    <= '0;
                  rate_code       <= '0;
                  rate_valid      <= 1'b0;
                  min_bin         <= '0;
                  max_bin         <= '0;
                  found           <= 1'b0;
                  first_edge      <= 1'b1;
                  sample_counter  <= '0;
                  interval        <= '0;
                  probe_busy      <= 1'b1;
                  state           <= WAIT_INDEX;
               end
            end

            WAIT_INDEX: begin
               // Counter doubles as the missing-index timeout.
               if (index_pulse || sample_counter > {1'b0, WINDOW}) begin
                  sample_counter <= '0;
                  interval       <= '0;
                  state          <= SAMPLE;
               end else begin
                  sample_counter <= sample_counter + 25'd1;
               end
            end

            SAMPLE: begin
               interval <= flux_edge ? 10'd0 : ival_next;
               if (flux_edge) begin
                  // The first edge only starts the first interval.
                  if (first_edge)
                     first_edge <= 1'b0;
                  else if (ival_next < GLITCH_MIN) begin
                     if (glitch_count != 8'hFF) glitch_count <= glitch_count + 8'd1;
                  end else if (ival_next >= 10'd256) begin
                     if (overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
                  end else begin
                     if (hist[ival_next[7:4]] != 16'hFFFF)
                        hist[ival_next[7:4]] <= hist[ival_next[7:4]] + 16'd1;
                     if (total_intervals != 16'hFFFF)
                        total_intervals <= total_intervals + 16'd1;
                  end
               end
               if (sample_counter == {1'b0, WINDOW - 24'd1}) begin
                  scan_idx <= '0;
                  state    <= SCAN;
               end else begin
                  sample_counter <= sample_counter + 25'd1;
               end
            end

            SCAN: begin
               if (hist[scan_idx] >= MIN_BIN_HITS) begin
                  if (!found) min_bin <= scan_idx;
                  max_bin <= scan_idx;
                  found   <= 1'b1;
               end
               if (scan_idx == 4'd15) state <= CLASSIFY;
               else                   scan_idx <= scan_idx + 4'd1;
            end

            CLASSIFY: begin
               rate_code  <= code;
               rate_valid <= (code != 2'd0);
               probe_done <= 1'b1;
               probe_busy <= 1'b0;
               state      <= DONE;
            end

            DONE: begin
               probe_done <= 1'b0;
               state      <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef HDD_RATE_HIST_READBACK_EN
   always_ff @(posedge clk) begin
      if (!reset_n) hist_count <= '0;
      else          hist_count <= hist[hist_sel];
   end
`endif

endmodule

// File: tb/tb_hdd_rate_probe.sv
// Bench for hdd_rate_probe: directed MFM/RLL/ESDI/glitch runs plus random
// interval runs. Each run is compared against a reference built from the
// list of edge times inside the sample window.
module tb_hdd_rate_probe;
   localparam int W    = 4000;
   localparam int GM   = 10;
   localparam int HITS = 4;
   localparam int MAXE = 2 * W + 300;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic probe_start = 1'b0, use_differential = 1'b0;
   logic read_data_se = 1'b0, read_data_p = 1'b0, read_data_n = 1'b0, index_pulse = 1'b0;
   logic probe_busy, probe_done, rate_valid;
   logic [1:0] rate_code;
   logic [3:0] min_bin, max_bin;
   logic [15:0] total_intervals, overflow_count;
   logic [7:0] glitch_count;
`ifdef HDD_RATE_HIST_READBACK_EN
   logic [3:0] hist_sel = 4'd0;
   logic [15:0] hist_count;
`endif

   hdd_rate_probe #(.WINDOW(24'd4000), .GLITCH_MIN(10'd10), .MIN_BIN_HITS(16'd4)) dut (
      .clk(clk), .reset_n(reset_n), .probe_start(probe_start),
      .use_differential(use_differential), .read_data_se(read_data_se),
      .read_data_p(read_data_p), .read_data_n(read_data_n), .index_pulse(index_pulse),
`ifdef HDD_RATE_HIST_READBACK_EN
      .hist_sel(hist_sel), .hist_count(hist_count),
`endif
      .probe_busy(probe_busy), .probe_done(probe_done), .rate_valid(rate_valid),
      .rate_code(rate_code), .min_bin(min_bin), .max_bin(max_bin),
      .total_intervals(total_intervals), .overflow_count(overflow_count),
      .glitch_count(glitch_count));

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, probe_busy, 0);
      chk({tag, "_done"}, probe_done, 0);
      chk({tag, "_valid"}, rate_valid, 0);
      chk({tag, "_code"}, rate_code, 0);
      chk({tag, "_min"}, min_bin, 0);
      chk({tag, "_max"}, max_bin, 0);
      chk({tag, "_total"}, total_intervals, 0);
      chk({tag, "_ovf"}, overflow_count, 0);
      chk({tag, "_glitch"}, glitch_count, 0);
`ifdef HDD_RATE_HIST_READBACK_EN
      chk({tag, "_hcnt"}, hist_count, 0);
`endif
   endtask

   // ---- stimulus generator: line toggles after each chosen interval ----
   int  gen_kind, gen_step, gen_rem;
   bit  line_val = 1'b0, cur_diff, n_const;
   logic sel_q [0:MAXE];

   function automatic int next_iv();
      int v;
      case (gen_kind)
         0: case (gen_step % 3) 0: v = 60; 1: v = 90; default: v = 120; endcase
         1: v = 60 + 20 * (gen_step % 6);
         2: case (gen_step % 3) 0: v = 30; 1: v = 45; default: v = 60; endcase
         3: v = (gen_step % 2 == 0) ? 3 : 9;
         default: v = int'($urandom_range(2, 300));
      endcase
      gen_step++;
      return v;
   endfunction

   task automatic gen_tick();
      if (gen_rem <= 1) begin
         line_val = ~line_val;
         gen_rem  = next_iv();
      end else gen_rem--;
   endtask

   // Selected line carries the pattern; the other source carries noise.
   task automatic drive_data();
      if (cur_diff) begin
         read_data_n  = n_const;
         read_data_p  = line_val ^ n_const;
         read_data_se = 1'($urandom_range(0, 1));
      end else begin
         read_data_se = line_val;
         read_data_p  = 1'($urandom_range(0, 1));
         read_data_n  = 1'($urandom_range(0, 1));
      end
   endtask

   // ---- reference: intervals are differences of edge times in the window ----
   int m_hist [16];
   int m_total, m_ovf, m_glitch, m_min, m_max, m_code;

   task automatic model(input int s);
      int prev, iv;
      bit have, found;
      for (int i = 0; i < 16; i++) m_hist[i] = 0;
      m_total = 0; m_ovf = 0; m_glitch = 0; have = 0; prev = 0;
      for (int e = s; e < s + W; e++) begin
         if (sel_q[e] !== sel_q[e-1]) begin
            if (have) begin
               iv = e - prev;
               if (iv < GM) m_glitch = (m_glitch < 255) ? m_glitch + 1 : 255;
               else if (iv >= 256) m_ovf = (m_ovf < 65535) ? m_ovf + 1 : 65535;
               else begin
                  if (m_hist[iv/16] < 65535) m_hist[iv/16]++;
                  if (m_total < 65535) m_total++;
               end
            end
            have = 1;
            prev = e;
         end
      end
      found = 0; m_min = 0; m_max = 0;
      for (int i = 0; i < 16; i++)
         if (m_hist[i] >= HITS) begin
            if (!found) m_min = i;
            m_max = i;
            found = 1;
         end
      if (!found) m_code = 0;
      else if (m_min == 1 || m_min == 2) m_code = 3;
      else if (m_min == 3 || m_min == 4) m_code = (m_max >= 9) ? 2 : 1;
      else m_code = 0;
   endtask

   // One probe: idx_at = edge carrying index (-1 none), abort_at = edge where
   // reset is applied (-1 none), inject_at = edge with an extra start while busy.
   task automatic run_probe(input string tag, input int kind, input bit diff,
                            input int idx_at, input int abort_at, input int inject_at,
                            input int exp_code, input int exp_min, input int exp_max);
      int e, s, cnt;
      bit got_done;
      gen_kind = kind; gen_step = 0; gen_rem = next_iv();
      cur_diff = diff;
      probe_start = 1'b1; use_differential = diff;
      drive_data(); sel_q[0] = line_val;
      @(posedge clk); #1;
      probe_start = 1'b0;
      chk({tag, "_busy_start"}, probe_busy, 1);
      e = 0; got_done = 0;
      while (!got_done && e < MAXE - 1) begin
         index_pulse = (e + 1 == idx_at);
         probe_start = (e + 1 == inject_at);
         use_differential = (e + 1 == inject_at) ? ~diff : diff;
         gen_tick(); drive_data(); sel_q[e+1] = line_val;
         if (e + 1 == abort_at) reset_n = 1'b0;
         @(posedge clk); e++; #1;
         if (!reset_n) begin
            probe_start = 1'b0; index_pulse = 1'b0;
            chk_zero({tag, "_rst"});
            repeat (2) begin @(posedge clk); #1; chk_zero({tag, "_rsthold"}); end
            reset_n = 1'b1;
            cnt = 0;
            repeat (40) begin @(posedge clk); #1; cnt += probe_done; cnt += probe_busy; end
            chk({tag, "_stale_done"}, cnt, 0);
            return;
         end
         got_done = probe_done;
      end
      probe_start = 1'b0; index_pulse = 1'b0; use_differential = diff;
      if (!got_done) begin
         chk({tag, "_done_timeout"}, 0, 1);
         return;
      end
      s = (idx_at >= 1 && idx_at <= W + 2) ? idx_at + 1 : W + 3;
      model(s);
      chk({tag, "_latency"}, e, s + W + 16);
      chk({tag, "_busy_done"}, probe_busy, 0);
      chk({tag, "_code"}, rate_code, m_code);
      chk({tag, "_valid"}, rate_valid, m_code != 0);
      chk({tag, "_min"}, min_bin, m_min);
      chk({tag, "_max"}, max_bin, m_max);
      chk({tag, "_total"}, total_intervals, m_total);
      chk({tag, "_ovf"}, overflow_count, m_ovf);
      chk({tag, "_glitch"}, glitch_count, m_glitch);
      if (exp_code >= 0) chk({tag, "_code_spec"}, rate_code, exp_code);
      if (exp_min >= 0)  chk({tag, "_min_spec"}, min_bin, exp_min);
      if (exp_max >= 0)  chk({tag, "_max_spec"}, max_bin, exp_max);
      // Start during the DONE cycle must be ignored.
      probe_start = 1'b1;
      @(posedge clk); #1;
      probe_start = 1'b0;
      chk({tag, "_done_pulse"}, probe_done, 0);
      cnt = 0;
      repeat (5) begin @(posedge clk); #1; cnt += probe_busy; cnt += probe_done; end
      chk({tag, "_idle_after"}, cnt, 0);
      chk({tag, "_hold_code"}, rate_code, m_code);
`ifdef HDD_RATE_HIST_READBACK_EN
      for (int i = 0; i < 16; i++) begin
         hist_sel = 4'(i);
         @(posedge clk); #1;
         chk($sformatf("%s_hist%0d", tag, i), hist_count, m_hist[i]);
      end
`endif
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_const = 1'b0;
      run_probe("mfm",  0, 1'b0, 100, -1, -1, 1, 3, 7);
      run_probe("rll",  1, 1'b1, 37,  -1, -1, 2, 3, 10);
      run_probe("esdi", 2, 1'b0, -1,  -1, -1, 3, 1, 3);
      run_probe("glt",  3, 1'b1, 12,  -1, -1, 0, 0, 0);
      chk("glt_sat", glitch_count, 255);
      // reset while idle with results present
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk_zero("rst_idle");
      reset_n = 1'b1;
      run_probe("abort", 0, 1'b0, 20, 1500, -1, -1, -1, -1);
      run_probe("fresh", 2, 1'b1, 5,  -1, 800, 3, 1, 3);
      for (int r = 0; r < 2; r++) begin
         n_const = 1'($urandom_range(0, 1));
         run_probe($sformatf("rnd%0d", r), 4, 1'($urandom_range(0, 1)),
                   int'($urandom_range(1, 60)), -1, int'($urandom_range(100, 3000)), -1, -1, -1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/hdd_rate_probe.md
Name: hdd_rate_probe

Overview:
- Second stage of the HDD discovery pipeline. Runs after the PHY probe and mode controller have picked single-ended or differential read data.
- Builds a 16-bin histogram of flux-transition intervals over a fixed window at 300 MHz.
- Scans the histogram for shortest and longest populated intervals, then classifies the data rate/encoding: MFM 5 Mbps, RLL 7.5 Mbps, or ESDI 10 Mbps.

Parameters:
- WINDOW, 24'd1_500_000, sample window length in clk cycles; also the index-wait timeout.
- GLITCH_MIN, 10'd10, intervals shorter than this are glitches and are not binned.
- MIN_BIN_HITS, 16'd64, minimum bin count for a bin to count as "populated".

Ports:
- clk  in  1  300 MHz HDD clock
- reset_n  in  1  synchronous active-low reset
- probe_start  in  1  one-cycle start pulse; ignored while probe_busy=1
- use_differential  in  1  1: use read_data_p^read_data_n; 0: use read_data_se; latched at start
- read_data_se  in  1  single-ended read data
- read_data_p  in  1  differential positive
- read_data_n  in  1  differential negative
- index_pulse  in  1  index reference
- probe_busy  out  1  high from the cycle after an accepted start until DONE
- probe_done  out  1  one-cycle pulse on DONE
- rate_valid  out  1  classification succeeded (rate_code!=0)
- rate_code  out  2  0 unknown, 1 MFM 5M, 2 RLL 7.5M, 3 ESDI 10M
- min_bin  out  4  lowest populated bin (0 if none)
- max_bin  out  4  highest populated bin (0 if none)
- total_intervals  out  16  binned intervals, saturating
- overflow_count  out  16  intervals >=256 clk, saturating
- glitch_count  out  8  intervals <GLITCH_MIN, saturating

Behaviour:
- Reset (reset_n=0 at a clk edge) returns every output to 0, histogram to 0, and state to IDLE. This applies mid-operation too; no probe_done is issued.
- Edge detect: selected data registered once (d_prev); edge = d_prev ^ d. Source is fixed by use_differential as captured on the start cycle.
- IDLE: on probe_start, clear histogram, all counters and results, first_edge=1, sample_counter=0, interval=0, then go to WAIT_INDEX.
- WAIT_INDEX: index_pulse=1 or sample_counter>WINDOW → SAMPLE, with sample_counter=0 and interval=0. Otherwise sample_counter++.
- SAMPLE: lasts exactly WINDOW cycles (counter 0..WINDOW-1). An edge on the last cycle is processed.
  - interval increments each cycle, saturating at 1023.
  - On edge, if first_edge=1: clear first_edge; nothing recorded.
  - On edge, else if interval<GLITCH_MIN: glitch_count++.
  - On edge, else if interval>=256: overflow_count++.
  - On edge, else: hist[interval[7:4]]++ and total_intervals++. All saturate at max.
  - interval resets to 0 on every edge, including glitches.
- SCAN: 16 cycles, index i=0..15. If hist[i]>=MIN_BIN_HITS: if no hit yet, min_bin=i; always max_bin=i; set found.
- CLASSIFY (1 cycle):
  - found=0 → code 0.
  - min_bin in {1,2} → code 3.
  - min_bin in {3,4}: max_bin>=9 → code 2, else → code 1.
  - Otherwise → code 0.
  - rate_valid=(code!=0).
- DONE: probe_done=1 for one cycle, probe_busy=0, → IDLE. Results hold until the next accepted start.
- Latency from start to done, index present at cycle k: 1 + k + WINDOW + 16 + 1 + 1 cycles.
- probe_start arriving during the DONE cycle is ignored; it is accepted in IDLE only.

Optional Feature:
- Macro: HDD_RATE_HIST_READBACK_EN.
- When defined: adds input hist_sel[3:0] and output hist_count[15:0]. hist_count = hist[hist_sel], registered, 1-cycle latency, valid in any state; hist_count resets to 0.
- When undefined: those ports do not exist; histogram is internal only.

Test Plan:
- MFM stimulus, SE, index at cycle 100: intervals cycling 60/90/120 clk → min_bin=3, max_bin=7, rate_code=1, rate_valid=1, glitch_count=0.
- RLL stimulus, differential (p toggles, n=0), intervals 60..160 clk in 20-clk steps → rate_code=2, max_bin=10; the read_data_se toggles are ignored.
- ESDI stimulus, intervals 30/45/60 clk, no index → timeout after WINDOW+2 cycles, then sampling; rate_code=3, min_bin=1.
- Idle line plus a 3-clk glitch burst every 500 clk → glitch_count=255 (saturated), found=0, rate_code=0, rate_valid=0, probe_done still pulses.
- reset_n=0 mid-SAMPLE, then probe_start → no stale done; all outputs 0 during reset; the second run produces correct fresh results. A probe_start issued while busy is ignored, with no extra done.
- With HDD_RATE_HIST_READBACK_EN and the MFM stimulus: hist_sel=3 → hist_count equals the expected count of 60-clk intervals one cycle later.
